// File: rtl/axis_iter_div.sv
// Radix-2 restoring divider behind two AXI-stream operand channels; returns {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: skip the iteration when the divisor is zero or |dividend| < |divisor|.
module axis_iter_div #(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  output logic                  m_axis_dout_tvalid,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic                have_dvd_q, have_dvd_d, have_dvs_q, have_dvs_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
  logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, bmag_q, bmag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [2*DATA_W-1:0] dout_q, dout_d;

  logic                dvd_fire, dvs_fire;
  logic                a_neg, b_neg, borrow;
  logic [DATA_W-1:0]   a_mag, b_mag, rem_step, quo_step, q_fix, r_fix;
  logic [DATA_W:0]     shifted;

  assign s_axis_dividend_tready = (state_q == IDLE) && !have_dvd_q && !reset;
  assign s_axis_divisor_tready  = (state_q == IDLE) && !have_dvs_q && !reset;
  assign dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;

  assign m_axis_dout_tvalid = (state_q == DONE);
  assign m_axis_dout_tdata  = dout_q;

  // Magnitudes fit in DATA_W bits unsigned, including |-2^(DATA_W-1)|. The partial
  // remainder stays below |divisor|, so only the shifted trial value needs an extra bit.
  always_comb begin
    a_neg    = SIGNED && dvd_q[DATA_W-1];
    b_neg    = SIGNED && dvs_q[DATA_W-1];
    a_mag    = a_neg ? -dvd_q : dvd_q;
    b_mag    = b_neg ? -dvs_q : dvs_q;
    shifted  = {rem_q, quo_q[DATA_W-1]};
    borrow   = shifted < {1'b0, bmag_q};
    rem_step = borrow ? shifted[DATA_W-1:0] : shifted[DATA_W-1:0] - bmag_q;
    quo_step = {quo_q[DATA_W-2:0], !borrow};
    q_fix    = qneg_q ? -quo_step : quo_step;
    r_fix    = rneg_q ? -rem_step : rem_step;
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    have_dvd_d = have_dvd_q;
    have_dvs_d = have_dvs_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bmag_d     = bmag_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    dout_d     = dout_q;

    if (dvd_fire) begin
      have_dvd_d = 1'b1;
      dvd_d      = s_axis_dividend_tdata;
    end
    if (dvs_fire) begin
      have_dvs_d = 1'b1;
      dvs_d      = s_axis_divisor_tdata;
    end

    case (state_q)
      IDLE: if (have_dvd_q && have_dvs_q) state_d = LOAD;
      LOAD: begin
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
        dz_d    = (dvs_q == '0);
        rem_d   = '0;
        quo_d   = a_mag;
        bmag_d  = b_mag;
        cnt_d   = CNT_W'(DATA_W - 1);
        state_d = BUSY;
`ifdef DIV_EARLY_OUT_EN
        if ((dvs_q == '0) || (a_mag < b_mag)) begin
          state_d = DONE;
          dout_d  = (dvs_q == '0) ? {dvd_q, {DATA_W{1'b1}}} : {dvd_q, {DATA_W{1'b0}}};
        end
`endif
      end
      BUSY: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          // Divide by zero bypasses sign correction: remainder is the raw dividend.
          dout_d  = dz_q ? {dvd_q, {DATA_W{1'b1}}} : {r_fix, q_fix};
        end
      end
      DONE: begin
        state_d    = IDLE;
        have_dvd_d = 1'b0;
        have_dvs_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Flush discards any held or in-flight work, including an operand arriving this cycle.
    if (flush) begin
      state_d    = IDLE;
      have_dvd_d = 1'b0;
      have_dvs_d = 1'b0;
      dout_d     = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= IDLE;
      have_dvd_q <= 1'b0;
      have_dvs_q <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bmag_q     <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      have_dvd_q <= have_dvd_d;
      have_dvs_q <= have_dvs_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bmag_q     <= bmag_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      dout_q     <= dout_d;
    end
  end

endmodule
